// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: hazard/redirect control,
// instruction memory port and the IF/ID boundary presented to decode.
interface fetch_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] issued_cnt;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_rdata,
        output imem_addr,
        output id_inst,
        output id_pc,
        output id_pc4,
        output id_valid,
        output issued_cnt
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output imem_rdata,
        input  imem_addr,
        input  id_inst,
        input  id_pc,
        input  id_pc4,
        input  id_valid,
        input  issued_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and holds
// the IF/ID boundary, with stall hold and 2-bubble redirect squash.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        BUBBLE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_f_r;
    logic [31:0] pc_f_s;
    logic [31:0] pc_d_r;
    logic [31:0] pc_d_s;
    logic [31:0] hold_inst_r;
    logic [31:0] hold_inst_s;
    logic [31:0] issued_cnt_r;
    logic [31:0] issued_cnt_s;
    logic        id_valid_s;
    logic [31:0] id_inst_s;

    // State and PC registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= BOOT;
            pc_f_r       <= RESET_PC;
            pc_d_r       <= RESET_PC;
            hold_inst_r  <= NOP_INST;
            issued_cnt_r <= 32'd0;
        end else begin
            state_r      <= state_s;
            pc_f_r       <= pc_f_s;
            pc_d_r       <= pc_d_s;
            hold_inst_r  <= hold_inst_s;
            issued_cnt_r <= issued_cnt_s;
        end
    end

    // Next-state logic: redirect beats stall beats advance
    always_comb begin
        state_s      = state_r;
        pc_f_s       = pc_f_r;
        pc_d_s       = pc_d_r;
        hold_inst_s  = hold_inst_r;
        if (bus.redirect_valid) begin
            state_s = BUBBLE;
            pc_f_s  = bus.redirect_pc & ~32'h0000_0003;
            pc_d_s  = bus.redirect_pc & ~32'h0000_0003;
        end else begin
            case (state_r)
                BOOT, BUBBLE: begin
                    state_s = RUN;
                    pc_d_s  = pc_f_r;
                    pc_f_s  = pc_f_r + 32'd4;
                end
                RUN: begin
                    if (bus.stall) begin
                        state_s     = HOLD;
                        hold_inst_s = bus.imem_rdata;
                    end else begin
                        state_s = RUN;
                        pc_d_s  = pc_f_r;
                        pc_f_s  = pc_f_r + 32'd4;
                    end
                end
                HOLD: begin
                    // imem_addr was frozen, so the next read returns the instruction after the held one
                    if (bus.stall) begin
                        state_s = HOLD;
                    end else begin
                        state_s = RUN;
                        pc_d_s  = pc_f_r;
                        pc_f_s  = pc_f_r + 32'd4;
                    end
                end
                default: begin
                    state_s = BOOT;
                end
            endcase
        end
        if (id_valid_s && !bus.stall && !bus.redirect_valid) begin
            issued_cnt_s = issued_cnt_r + 32'd1;
        end else begin
            issued_cnt_s = issued_cnt_r;
        end
    end

    // ID-boundary outputs decoded from the current state
    always_comb begin
        id_valid_s = 1'b0;
        id_inst_s  = NOP_INST;
        case (state_r)
            BOOT: begin
                id_valid_s = 1'b0;
                id_inst_s  = NOP_INST;
            end
            RUN: begin
                id_valid_s = 1'b1;
                id_inst_s  = bus.imem_rdata;
            end
            HOLD: begin
                id_valid_s = 1'b1;
                id_inst_s  = hold_inst_r;
            end
            BUBBLE: begin
                id_valid_s = 1'b0;
                id_inst_s  = NOP_INST;
            end
            default: begin
                id_valid_s = 1'b0;
                id_inst_s  = NOP_INST;
            end
        endcase
    end

    assign bus.imem_addr  = pc_f_r;
    assign bus.id_pc      = pc_d_r;
    assign bus.id_pc4     = pc_d_r + 32'd4;
    assign bus.id_valid   = id_valid_s;
    assign bus.id_inst    = id_inst_s;
    assign bus.issued_cnt = issued_cnt_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a program-order model predicts each cycle's ID slot,
// a negedge monitor compares it with the DUT outputs.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous instruction memory with a 1-cycle read latency
    always @(posedge clk) bus.imem_rdata <= inst_of(bus.imem_addr);

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] upcoming;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model: the instruction occupying ID (valid/pc), the next program-order PC when ID is empty,
    // and how many instructions have left ID.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_up;
    logic [31:0] m_cnt;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] epc;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            epc = e.valid ? e.pc : e.upcoming;
            check32("id_valid", {31'd0, bus.id_valid}, {31'd0, e.valid});
            check32("id_pc", bus.id_pc, epc);
            check32("id_pc4", bus.id_pc4, epc + 32'd4);
            check32("id_inst", bus.id_inst, e.valid ? inst_of(e.pc) : NOP);
            check32("imem_addr", bus.imem_addr, e.valid ? e.pc + 32'd4 : e.upcoming);
            check32("issued_cnt", bus.issued_cnt, e.cnt);
        end
    end

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = RESET_PC;
        m_up    = RESET_PC;
        m_cnt   = 32'd0;
    endtask

    task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt);
        exp_t e;
        e.valid    = m_valid;
        e.pc       = m_pc;
        e.upcoming = m_up;
        e.cnt      = m_cnt;
        exp_q.push_back(e);
        bus.stall          = st;
        bus.redirect_valid = rd;
        bus.redirect_pc    = tgt;
        @(posedge clk);
        if (m_valid && !st && !rd) m_cnt = m_cnt + 32'd1;
        if (rd) begin
            m_valid = 1'b0;
            m_up    = tgt & ~32'h0000_0003;
        end else if (!m_valid) begin
            m_valid = 1'b1;
            m_pc    = m_up;
        end else if (!st) begin
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        rst = 1'b0;
        do_reset();
        // Reset release, stall at I1, redirect to 0x40
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 32'h0000_0040);
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        // Redirect together with stall while holding
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'h0000_0080);
        repeat (3) cyc(1'b0, 1'b0, 32'd0);
        // Misaligned target, then PC wrap at the top of the address space
        cyc(1'b0, 1'b1, 32'h0000_0043);
        repeat (3) cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (4) cyc(1'b0, 1'b0, 32'd0);
        // Asynchronous reset between edges while holding
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check32("async_rst id_valid", {31'd0, bus.id_valid}, 32'd0);
        check32("async_rst id_inst", bus.id_inst, NOP);
        check32("async_rst id_pc", bus.id_pc, RESET_PC);
        check32("async_rst imem_addr", bus.imem_addr, RESET_PC);
        check32("async_rst issued_cnt", bus.issued_cnt, 32'd0);
        bus.stall = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) cyc(1'b0, 1'b0, 32'd0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: tgt = $urandom_range(0, 255);
            endcase
            cyc(st, rd, tgt);
        end
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        check32("scoreboard_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
